// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB TX packet path:
//                sequencer state codes (decoded by the packet compiler),
//                packet types, PID bytes, SYNC pattern and the USB CRC16
//                constants plus a byte-wide CRC16 step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    // State codes are visible on c_state_TX and decoded by the packet compiler.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PID     = 3'd2,
        ST_DATA_TX = 3'd3,
        ST_CRC_LO  = 3'd4,
        ST_CRC_HI  = 3'd5,
        ST_EOP     = 3'd6,
        ST_DONE    = 3'd7
    } tx_state_t;

    typedef enum logic [2:0] {
        PKT_DATA0 = 3'd0,
        PKT_DATA1 = 3'd1,
        PKT_ACK   = 3'd2,
        PKT_NAK   = 3'd3,
        PKT_STALL = 3'd4
    } tx_packet_t;

    // Per-byte sub-phase inside DATA_TX: pop the buffer, capture the read
    // data one cycle later, then wait for the serializer to take it.
    typedef enum logic [1:0] {
        PH_POP  = 2'd0,
        PH_CAP  = 2'd1,
        PH_WAIT = 2'd2
    } data_phase_t;

    localparam logic [7:0] c_PID_DATA0 = 8'hC3;
    localparam logic [7:0] c_PID_DATA1 = 8'h4B;
    localparam logic [7:0] c_PID_ACK   = 8'hD2;
    localparam logic [7:0] c_PID_NAK   = 8'h5A;
    localparam logic [7:0] c_PID_STALL = 8'h1E;

    localparam logic [7:0] c_SYNC_BYTE = 8'h80;

    function automatic logic [15:0] reflect16(input logic [15:0] val);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = val[15-i];
        end
        return r;
    endfunction

    localparam logic [15:0] c_CRC16_POLY      = 16'h8005;
    // Bits go out LSB first, so the register shifts right with the
    // bit-reversed polynomial.
    localparam logic [15:0] c_CRC16_POLY_REFL = reflect16(c_CRC16_POLY);
    localparam logic [15:0] c_CRC16_INIT      = 16'hFFFF;
    // Register value left after running a good packet's CRC through the
    // (uncomplemented) reflected register.
    localparam logic [15:0] c_CRC16_RESIDUAL  = 16'hB001;

    function automatic logic [7:0] pid_byte(input tx_packet_t pkt);
        case (pkt)
            PKT_DATA0: return c_PID_DATA0;
            PKT_DATA1: return c_PID_DATA1;
            PKT_ACK:   return c_PID_ACK;
            PKT_NAK:   return c_PID_NAK;
            default:   return c_PID_STALL;
        endcase
    endfunction

    function automatic logic is_data_pkt(input tx_packet_t pkt);
        return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
    endfunction

    // One byte through the reflected CRC16 register, LSB of the byte first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ c_CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_sequencer_if
//  Description : Handshake/bus bundle around the TX sequencer.
//                master : protocol/endpoint logic, TX buffer, serializer and
//                         encoder side (drives requests, data, acks).
//                slave  : the sequencer itself.
//  Ports       : TX_Start, TX_Packet[2:0], Buffer_Occupancy[6:0],
//                TX_Packet_Data[7:0], byte_ack, eop_done   (to sequencer)
//                byte_TX[7:0], byte_ready_TX, c_state_TX[2:0],
//                Get_TX_Packet_Data, eop_req, TX_Transfer_Active, TX_Error,
//                payload_count[6:0]                        (from sequencer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_sequencer_if;

    logic       TX_Start;
    logic [2:0] TX_Packet;
    logic [6:0] Buffer_Occupancy;
    logic [7:0] TX_Packet_Data;
    logic       byte_ack;
    logic       eop_done;

    logic [7:0] byte_TX;
    logic       byte_ready_TX;
    logic [2:0] c_state_TX;
    logic       Get_TX_Packet_Data;
    logic       eop_req;
    logic       TX_Transfer_Active;
    logic       TX_Error;
    logic [6:0] payload_count;

    modport master (
        output TX_Start, TX_Packet, Buffer_Occupancy, TX_Packet_Data,
               byte_ack, eop_done,
        input  byte_TX, byte_ready_TX, c_state_TX, Get_TX_Packet_Data,
               eop_req, TX_Transfer_Active, TX_Error, payload_count
    );

    modport slave (
        input  TX_Start, TX_Packet, Buffer_Occupancy, TX_Packet_Data,
               byte_ack, eop_done,
        output byte_TX, byte_ready_TX, c_state_TX, Get_TX_Packet_Data,
               eop_req, TX_Transfer_Active, TX_Error, payload_count
    );

endinterface
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : usb_crc16
//  Description : Running USB CRC16 register, one byte per enabled cycle.
//                Holds the raw (uncomplemented) reflected remainder.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_clr        - return the register to the init value
//                i_en         - fold i_data into the CRC this cycle
//                i_data[7:0]  - byte to fold in
//                o_crc[15:0]  - current raw remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_crc <= c_CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_sequencer
//  Description : Packet-level USB TX controller. Sequences SYNC, PID,
//                payload, CRC16 and EOP towards the packet compiler and
//                serializer, pulling payload bytes from the TX buffer.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset (abandons any packet)
//                bus  - usb_tx_sequencer_if.slave: request/type/occupancy,
//                       buffer pop and data, byte strobe/ack, EOP req/done,
//                       state code, activity, error and payload count
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = usb_tx_pkg::c_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    usb_tx_sequencer_if.slave bus
);

    localparam logic [6:0] c_MAX_OCC = 7'(MAX_PAYLOAD);

    tx_state_t   r_state,  w_state;
    data_phase_t r_phase,  w_phase;
    tx_packet_t  r_type,   w_type;
    logic [6:0]  r_occ,    w_occ;
    logic [6:0]  r_count,  w_count;
    logic [7:0]  r_byte,   w_byte;
    logic        r_strobe, w_strobe;
    logic        r_get,    w_get;
    logic        r_error,  w_error;

    logic        w_crc_clr;
    logic        w_crc_en;
    logic [15:0] w_crc_raw;
    logic [15:0] w_crc_tx;
    logic [6:0]  w_count_inc;
    logic        w_req_legal;
    logic        w_req_is_data;
    logic        w_req_ok;

    usb_crc16 u_crc16 (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_crc_clr),
        .i_en   (w_crc_en),
        .i_data (bus.TX_Packet_Data),
        .o_crc  (w_crc_raw)
    );

    // The wire format carries the complemented remainder.
    assign w_crc_tx = ~w_crc_raw;

    assign w_count_inc   = r_count + 7'd1;
    assign w_req_legal   = (bus.TX_Packet <= PKT_STALL);
    assign w_req_is_data = (bus.TX_Packet == PKT_DATA0) || (bus.TX_Packet == PKT_DATA1);
    assign w_req_ok      = w_req_legal && !(w_req_is_data && (bus.Buffer_Occupancy > c_MAX_OCC));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_POP;
            r_type   <= PKT_DATA0;
            r_occ    <= '0;
            r_count  <= '0;
            r_byte   <= '0;
            r_strobe <= 1'b0;
            r_get    <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_phase  <= w_phase;
            r_type   <= w_type;
            r_occ    <= w_occ;
            r_count  <= w_count;
            r_byte   <= w_byte;
            r_strobe <= w_strobe;
            r_get    <= w_get;
            r_error  <= w_error;
        end
    end

    // Strobes (byte_ready_TX, Get_TX_Packet_Data, TX_Error) default low so
    // each is a single-cycle pulse; byte_TX holds until overwritten.
    always_comb begin
        w_state   = r_state;
        w_phase   = r_phase;
        w_type    = r_type;
        w_occ     = r_occ;
        w_count   = r_count;
        w_byte    = r_byte;
        w_strobe  = 1'b0;
        w_get     = 1'b0;
        w_error   = 1'b0;
        w_crc_clr = 1'b0;
        w_crc_en  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.TX_Start) begin
                    if (w_req_ok) begin
                        w_type   = tx_packet_t'(bus.TX_Packet);
                        w_occ    = bus.Buffer_Occupancy;
                        w_state  = ST_SYNC;
                        w_byte   = SYNC_BYTE;
                        w_strobe = 1'b1;
                    end else begin
                        w_error  = 1'b1;
                    end
                end
            end

            ST_SYNC: begin
                if (bus.byte_ack) begin
                    w_state  = ST_PID;
                    w_byte   = pid_byte(r_type);
                    w_strobe = 1'b1;
                end
            end

            ST_PID: begin
                if (bus.byte_ack) begin
                    if (!is_data_pkt(r_type)) begin
                        w_state = ST_EOP;
                    end else if (r_occ == 7'd0) begin
                        w_state  = ST_CRC_LO;
                        w_byte   = w_crc_tx[7:0];
                        w_strobe = 1'b1;
                    end else begin
                        w_state = ST_DATA_TX;
                        w_phase = PH_POP;
                        w_get   = 1'b1;
                    end
                end
            end

            ST_DATA_TX: begin
                case (r_phase)
                    PH_POP: begin
                        // Pop is on the bus this cycle; data arrives next.
                        w_phase = PH_CAP;
                    end
                    PH_CAP: begin
                        w_byte   = bus.TX_Packet_Data;
                        w_strobe = 1'b1;
                        w_crc_en = 1'b1;
                        w_phase  = PH_WAIT;
                    end
                    default: begin
                        if (bus.byte_ack) begin
                            w_count = w_count_inc;
                            if (w_count_inc == r_occ) begin
                                // CRC already includes this byte (folded in at capture).
                                w_state  = ST_CRC_LO;
                                w_byte   = w_crc_tx[7:0];
                                w_strobe = 1'b1;
                            end else begin
                                w_phase = PH_POP;
                                w_get   = 1'b1;
                            end
                        end
                    end
                endcase
            end

            ST_CRC_LO: begin
                if (bus.byte_ack) begin
                    w_state  = ST_CRC_HI;
                    w_byte   = w_crc_tx[15:8];
                    w_strobe = 1'b1;
                end
            end

            ST_CRC_HI: begin
                if (bus.byte_ack) begin
                    w_state = ST_EOP;
                end
            end

            ST_EOP: begin
                if (bus.eop_done) begin
                    w_state = ST_DONE;
                end
            end

            default: begin
                w_state   = ST_IDLE;
                w_phase   = PH_POP;
                w_count   = '0;
                w_byte    = '0;
                w_crc_clr = 1'b1;
            end
        endcase
    end

    assign bus.byte_TX            = r_byte;
    assign bus.byte_ready_TX      = r_strobe;
    assign bus.c_state_TX         = r_state;
    assign bus.Get_TX_Packet_Data = r_get;
    assign bus.eop_req            = (r_state == ST_EOP);
    assign bus.TX_Transfer_Active = (r_state != ST_IDLE);
    assign bus.TX_Error           = r_error;
    assign bus.payload_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_sequencer
//  Description : Self-checking bench for usb_tx_sequencer. A table of packet
//                requests with hand-computed expectations drives a small
//                serializer/buffer/encoder model; extra row flags cover the
//                mid-packet reset and spurious-input sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

    logic clk;
    logic rst;

    usb_tx_sequencer_if bus ();

    usb_tx_sequencer #(
        .MAX_PAYLOAD (64),
        .SYNC_BYTE   (8'h80)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  pkt;
        logic [6:0]  occ;
        bit          exp_err;
        logic [7:0]  pid;
        logic [7:0]  base;     // payload byte k = base + step*k
        logic [7:0]  step;
        logic [15:0] crc;      // complemented CRC as sent, {hi, lo}
        int          rst_at;   // >0: reset after this many byte strobes
        bit          spur;     // spurious ack in IDLE + second start in PID
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] pkt, input logic [6:0] occ,
                                input bit err, input logic [7:0] pid, input logic [7:0] base,
                                input logic [7:0] step, input logic [15:0] crc,
                                input int rst_at, input bit spur);
        vec_t v;
        v.name = nm; v.pkt = pkt; v.occ = occ; v.exp_err = err; v.pid = pid;
        v.base = base; v.step = step; v.crc = crc; v.rst_at = rst_at; v.spur = spur;
        return v;
    endfunction

    function automatic logic [7:0] pay(input vec_t v, input int k);
        logic [7:0] kk;
        logic [7:0] r;
        kk = k[7:0];
        r  = v.base + v.step * kk;
        return r;
    endfunction

    // Non-reflected, MSB-first CRC16 fed LSB-first bits; the reflected USB
    // CRC equals the bit-reversed register, then complemented.
    function automatic logic [15:0] ref_crc(input logic [7:0] base, input logic [7:0] step, input int n);
        logic [15:0] r;
        logic [15:0] o;
        logic [7:0]  d;
        logic [7:0]  kk;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            kk = k[7:0];
            d  = base + step * kk;
            for (int i = 0; i < 8; i++) begin
                fb = r[15] ^ d[i];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int j = 0; j < 16; j++) o[j] = r[15-j];
        return ~o;
    endfunction

    task automatic run_row(input vec_t v);
        logic [7:0] got[$];
        logic [7:0] exp[$];
        logic [7:0] last_b;
        logic [2:0] st;
        int  n_pop = 0, n_err = 0, n_done = 0, pidx = 0, pc_eop = -1;
        int  ack_at = -1, data_at = -1, eop_at = -1;
        bit  left_idle = 0, act_bad = 0, hold_bad = 0, spur_done = 0;
        bit  finished = 0, rst_path = 0;
        bit  is_data;

        last_b  = 8'h00;
        is_data = (v.pkt <= 3'd1);

        if (v.spur) begin
            bus.byte_ack = 1'b1;
            @(negedge clk);
            bus.byte_ack = 1'b0;
            check({v.name, ".spur_ack_idle_state"}, 32'(bus.c_state_TX), 32'd0);
        end

        bus.TX_Start         = 1'b1;
        bus.TX_Packet        = v.pkt;
        bus.Buffer_Occupancy = v.occ;
        @(negedge clk);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.TX_Start = 1'b0;
            bus.byte_ack = 1'b0;
            bus.eop_done = 1'b0;
            st = bus.c_state_TX;
            if (st != 3'd0) left_idle = 1;
            if (bus.TX_Error) n_err++;
            if (bus.TX_Transfer_Active !== (st != 3'd0)) act_bad = 1;
            if (st == 3'd6) pc_eop = int'(bus.payload_count);
            if (st == 3'd7) n_done++;
            if (bus.byte_ready_TX) begin
                got.push_back(bus.byte_TX);
                last_b = bus.byte_TX;
                ack_at = cyc + 2;
            end
            if (cyc == ack_at) begin
                if (bus.byte_TX !== last_b) hold_bad = 1;
                bus.byte_ack = 1'b1;
            end
            if (bus.Get_TX_Packet_Data) begin
                n_pop++;
                data_at = cyc + 1;
            end
            if (cyc == data_at) begin
                bus.TX_Packet_Data = pay(v, pidx);
                pidx++;
            end else if (cyc == data_at + 1) begin
                bus.TX_Packet_Data = 8'hEE;
            end
            if (bus.eop_req && eop_at < 0) eop_at = cyc + 3;
            if (cyc == eop_at) begin
                if (!bus.eop_req) hold_bad = 1;
                bus.eop_done = 1'b1;
            end
            if (v.spur && st == 3'd2 && !spur_done) begin
                bus.TX_Start  = 1'b1;
                bus.TX_Packet = 3'd4;
                spur_done     = 1;
            end
            if (v.rst_at > 0 && got.size() == v.rst_at) begin
                rst_path = 1;
                break;
            end
            if (v.exp_err ? (cyc >= 8) : (left_idle && st == 3'd0)) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end

        if (rst_path) begin
            check({v.name, ".pops_before_rst"}, 32'(n_pop), 32'(v.rst_at - 2));
            check({v.name, ".state_before_rst"}, 32'(bus.c_state_TX), 32'd3);
            rst = 1'b1;
            bus.byte_ack = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check({v.name, ".state_after_rst"}, 32'(bus.c_state_TX), 32'd0);
            check({v.name, ".outputs_after_rst"},
                  32'({bus.byte_TX, bus.byte_ready_TX, bus.Get_TX_Packet_Data, bus.eop_req,
                       bus.TX_Transfer_Active, bus.TX_Error, bus.payload_count}), 32'd0);
            act_bad = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.byte_ready_TX || bus.eop_req || bus.Get_TX_Packet_Data ||
                    bus.c_state_TX != 3'd0) act_bad = 1;
            end
            check({v.name, ".quiet_after_rst"}, 32'(act_bad), 32'd0);
            return;
        end

        check({v.name, ".finished"}, 32'(finished), 32'd1);

        if (!v.exp_err) begin
            exp.push_back(8'h80);
            exp.push_back(v.pid);
            if (is_data) begin
                for (int k = 0; k < int'(v.occ); k++) exp.push_back(pay(v, k));
                exp.push_back(v.crc[7:0]);
                exp.push_back(v.crc[15:8]);
            end
        end

        check({v.name, ".n_bytes"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s.byte%0d", v.name, i), 32'(got[i]), 32'(exp[i]));
        end
        check({v.name, ".pops"}, 32'(n_pop), is_data && !v.exp_err ? 32'(v.occ) : 32'd0);
        check({v.name, ".tx_error"}, 32'(n_err), v.exp_err ? 32'd1 : 32'd0);
        check({v.name, ".eop_seen"}, 32'(eop_at >= 0), v.exp_err ? 32'd0 : 32'd1);
        check({v.name, ".active_consistent"}, 32'(act_bad), 32'd0);
        if (v.exp_err) begin
            check({v.name, ".left_idle"}, 32'(left_idle), 32'd0);
        end else begin
            check({v.name, ".hold"}, 32'(hold_bad), 32'd0);
            check({v.name, ".done_cycles"}, 32'(n_done), 32'd1);
            check({v.name, ".payload_count_eop"}, 32'(pc_eop), is_data ? 32'(v.occ) : 32'd0);
            check({v.name, ".payload_count_idle"}, 32'(bus.payload_count), 32'd0);
        end
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk("ack",           3'd2, 7'd5,   0, 8'hD2, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[1]  = mk("data0_9",       3'd0, 7'd9,   0, 8'hC3, 8'h31, 8'h01, 16'hB4C8, 0, 0);
        vecs[2]  = mk("data1_0",       3'd1, 7'd0,   0, 8'h4B, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[3]  = mk("data0_65",      3'd0, 7'd65,  1, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[4]  = mk("type5",         3'd5, 7'd3,   1, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[5]  = mk("type7",         3'd7, 7'd0,   1, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[6]  = mk("nak",           3'd3, 7'd0,   0, 8'h5A, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[7]  = mk("stall_occ100",  3'd4, 7'd100, 0, 8'h1E, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[8]  = mk("data1_64",      3'd1, 7'd64,  0, 8'h4B, 8'h05, 8'h0B, ref_crc(8'h05, 8'h0B, 64), 0, 0);
        vecs[9]  = mk("data0_1",       3'd0, 7'd1,   0, 8'hC3, 8'h00, 8'h00, ref_crc(8'h00, 8'h00, 1), 0, 0);
        vecs[10] = mk("data0_rst",     3'd0, 7'd9,   0, 8'hC3, 8'h31, 8'h01, 16'hB4C8, 5, 0);
        vecs[11] = mk("ack_after_rst", 3'd2, 7'd0,   0, 8'hD2, 8'h00, 8'h00, 16'h0000, 0, 0);
        vecs[12] = mk("ack_spur",      3'd2, 7'd0,   0, 8'hD2, 8'h00, 8'h00, 16'h0000, 0, 1);
        vecs[13] = mk("data0_again",   3'd0, 7'd9,   0, 8'hC3, 8'h31, 8'h01, 16'hB4C8, 0, 0);

        rst                  = 1'b1;
        bus.TX_Start         = 1'b0;
        bus.TX_Packet        = 3'd0;
        bus.Buffer_Occupancy = 7'd0;
        bus.TX_Packet_Data   = 8'h00;
        bus.byte_ack         = 1'b0;
        bus.eop_done         = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset.state", 32'(bus.c_state_TX), 32'd0);
        check("reset.outputs",
              32'({bus.byte_TX, bus.byte_ready_TX, bus.Get_TX_Packet_Data, bus.eop_req,
                   bus.TX_Transfer_Active, bus.TX_Error, bus.payload_count}), 32'd0);

        for (int r = 0; r < 14; r++) begin
            run_row(vecs[r]);
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
